mod_counter_cascade: RTL and testbench

Parametrised multi-digit modulo-BASE counter for the calculator datapath and display logic. It generalises the single-digit modulo-n counter to a cascade of DIGITS digits with ripple carry and borrow between digits. It adds up/down counting, synchronous clear and load, and wrap or saturate mode. A registered overflow/underflow pulse is provided for chaining to further counters.

---
 rtl/mod_counter_cascade.sv | 109 ++++++++++
 tb/tb_mod_counter_cascade.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mod_counter_cascade.sv
//------------------------------------------------------------------------------
// mod_counter_cascade
// Multi-digit modulo-BASE up/down counter with ripple carry/borrow between
// digits, synchronous clear/load (with per-digit clamp), wrap or saturate
// mode, and a registered one-cycle limit (overflow/underflow) pulse.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mod_counter_cascade #(
  parameter int DIGITS = 4,
  parameter int BASE   = 10,
  parameter int DW     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 up_dn,
  input  logic                 sat_mode,
  input  logic                 clr,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  output logic [DIGITS*DW-1:0] count,
  output logic                 ovf,
  output logic                 is_zero,
  output logic                 is_max
);

  localparam int            W       = DIGITS * DW;
  localparam logic [DW-1:0] DIG_MAX = DW'(BASE - 1);

  // A digit field must be able to hold BASE-1 and the modulus must be useful.
  generate
    if (BASE < 2 || BASE > (1 << DW)) begin : g_param_check
      $error("mod_counter_cascade: BASE must be in 2..2**DW");
    end
  endgenerate

  logic [W-1:0] count_q, count_d;
  logic         ovf_q, ovf_d;
  logic         all_max, all_zero;

  // Limit detection: every digit at BASE-1, or every digit at 0.
  always_comb begin
    all_max  = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (count_q[i*DW +: DW] != DIG_MAX) all_max  = 1'b0;
      if (count_q[i*DW +: DW] != '0)      all_zero = 1'b0;
    end
  end

  // Next-state: clr > load > en > hold. The carry/borrow enters at digit 0 and
  // propagates only through digits sitting at the rollover value.
  always_comb begin
    logic          carry;
    logic          limit;
    logic [DW-1:0] dig;
    logic [DW-1:0] ld;
    count_d = count_q;
    ovf_d   = 1'b0;
    carry   = 1'b1;
    limit   = up_dn ? all_max : all_zero;
    dig     = '0;
    ld      = '0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      for (int i = 0; i < DIGITS; i++) begin
        ld = load_val[i*DW +: DW];
        count_d[i*DW +: DW] = (ld > DIG_MAX) ? DIG_MAX : ld;
      end
    end else if (en) begin
      ovf_d = limit;
      // Saturating at a limit: keep the value, just report the attempt.
      if (!(limit && sat_mode)) begin
        for (int i = 0; i < DIGITS; i++) begin
          dig = count_q[i*DW +: DW];
          if (up_dn) begin
            if (carry) count_d[i*DW +: DW] = (dig == DIG_MAX) ? '0 : dig + DW'(1);
            carry = carry & (dig == DIG_MAX);
          end else begin
            if (carry) count_d[i*DW +: DW] = (dig == '0) ? DIG_MAX : dig - DW'(1);
            carry = carry & (dig == '0);
          end
        end
      end
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count   = count_q;
  assign ovf     = ovf_q;
  assign is_zero = all_zero;
  assign is_max  = all_max;

endmodule

`default_nettype wire

// File: tb/tb_mod_counter_cascade.sv
//------------------------------------------------------------------------------
// tb_mod_counter_cascade
// Self-checking bench: default (4 x BASE-10) and small (2 x BASE-6, DW=3)
// instances, directed steps followed by random stimulus, compared against an
// integer-valued reference model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mod_counter_cascade;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic        en_a = 0, up_a = 1, sat_a = 0, clr_a = 0, load_a = 0;
  logic [15:0] lv_a = '0;
  logic [15:0] cnt_a;
  logic        ovf_a, iz_a, im_a;

  // Instance B: DIGITS=2, BASE=6, DW=3
  logic        en_b = 0, up_b = 1, sat_b = 0, clr_b = 0, load_b = 0;
  logic [5:0]  lv_b = '0;
  logic [5:0]  cnt_b;
  logic        ovf_b, iz_b, im_b;

  mod_counter_cascade dut_a (
    .clk(clk), .rst(rst), .en(en_a), .up_dn(up_a), .sat_mode(sat_a),
    .clr(clr_a), .load(load_a), .load_val(lv_a), .count(cnt_a),
    .ovf(ovf_a), .is_zero(iz_a), .is_max(im_a)
  );

  mod_counter_cascade #(.DIGITS(2), .BASE(6), .DW(3)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .up_dn(up_b), .sat_mode(sat_b),
    .clr(clr_b), .load(load_b), .load_val(lv_b), .count(cnt_b),
    .ovf(ovf_b), .is_zero(iz_b), .is_max(im_b)
  );

  int pass_cnt = 0;
  int fail_cnt = 0;

  // Model state: the count as a plain integer value, plus the expected pulse.
  int   m_a = 0, m_b = 0;
  logic mo_a = 0, mo_b = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ipow(input int b, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  // Integer value -> packed digit fields.
  function automatic logic [15:0] pack(input int v, input int nd, input int b, input int dw);
    logic [15:0] r = '0;
    int t = v;
    for (int i = 0; i < nd; i++) begin
      r = r | (16'(t % b) << (i * dw));
      t = t / b;
    end
    return r;
  endfunction

  // One clock edge of the behavioural counter.
  function automatic void model_step(input int nd, input int b, input int dw, input int cur,
                                     input logic c, input logic l, input logic e,
                                     input logic u, input logic s, input logic [15:0] lv,
                                     output int nxt, output logic novf);
    int maxv = ipow(b, nd) - 1;
    int d;
    nxt  = cur;
    novf = 1'b0;
    if (c) nxt = 0;
    else if (l) begin
      nxt = 0;
      for (int i = 0; i < nd; i++) begin
        d = int'((lv >> (i * dw)) & ((16'd1 << dw) - 16'd1));
        if (d > b - 1) d = b - 1;
        nxt = nxt + d * ipow(b, i);
      end
    end else if (e) begin
      if (u) begin
        if (cur == maxv) begin novf = 1'b1; nxt = s ? maxv : 0; end
        else nxt = cur + 1;
      end else begin
        if (cur == 0) begin novf = 1'b1; nxt = s ? 0 : maxv; end
        else nxt = cur - 1;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    logic [15:0] pb;
    chk({tag, ".cnt_a"}, cnt_a, pack(m_a, 4, 10, 4));
    chk({tag, ".ovf_a"}, 16'(ovf_a), 16'(mo_a));
    chk({tag, ".iz_a"},  16'(iz_a),  16'(m_a == 0));
    chk({tag, ".im_a"},  16'(im_a),  16'(m_a == 9999));
    pb = pack(m_b, 2, 6, 3);
    chk({tag, ".cnt_b"}, 16'(cnt_b), pb);
    chk({tag, ".ovf_b"}, 16'(ovf_b), 16'(mo_b));
    chk({tag, ".iz_b"},  16'(iz_b),  16'(m_b == 0));
    chk({tag, ".im_b"},  16'(im_b),  16'(m_b == 35));
  endtask

  // Advance one edge, update the model from the sampled inputs, then check.
  task automatic step(input string tag);
    int   na, nb;
    logic oa, ob;
    @(posedge clk);
    if (rst) begin
      na = 0; nb = 0; oa = 0; ob = 0;
    end else begin
      model_step(4, 10, 4, m_a, clr_a, load_a, en_a, up_a, sat_a, lv_a, na, oa);
      model_step(2, 6, 3, m_b, clr_b, load_b, en_b, up_b, sat_b, 16'(lv_b), nb, ob);
    end
    m_a = na; mo_a = oa; m_b = nb; mo_b = ob;
    #1;
    check_all(tag);
  endtask

  task automatic set_a(input logic c, input logic l, input logic e, input logic u,
                       input logic s, input logic [15:0] lv);
    clr_a = c; load_a = l; en_a = e; up_a = u; sat_a = s; lv_a = lv;
  endtask

  initial begin
    // Reset state
    #12;
    check_all("reset");
    rst = 1'b0;

    // Test 1: count to 0x0123, then async reset between edges
    @(negedge clk);
    set_a(0, 1, 0, 1, 0, 16'h0120); step("t1.load");
    set_a(0, 0, 1, 1, 0, 16'h0);
    repeat (3) step("t1.up");
    chk("t1.at0123", cnt_a, 16'h0123);
    #2 rst = 1'b1;
    #1;
    m_a = 0; mo_a = 0; m_b = 0; mo_b = 0;
    chk("t1.async_cnt", cnt_a, 16'h0000);
    chk("t1.async_ovf", 16'(ovf_a), 16'h0);
    repeat (2) step("t1.in_rst");
    @(negedge clk) rst = 1'b0;
    step("t1.release");
    chk("t1.first", cnt_a, 16'h0001);

    // Test 2: up wrap, then ripple 0x0099 -> 0x0100
    set_a(0, 1, 0, 1, 0, 16'h9998); step("t2.load");
    set_a(0, 0, 1, 1, 0, 16'h0);
    step("t2.9999");
    step("t2.wrap");
    chk("t2.wrap_cnt", cnt_a, 16'h0000);
    chk("t2.wrap_ovf", 16'(ovf_a), 16'h1);
    step("t2.0001");
    set_a(0, 1, 0, 1, 0, 16'h0099); step("t2.load99");
    set_a(0, 0, 1, 1, 0, 16'h0);    step("t2.ripple");
    chk("t2.0100", cnt_a, 16'h0100);

    // Test 3: borrow and down wrap
    set_a(0, 1, 0, 0, 0, 16'h1000); step("t3.load");
    set_a(0, 0, 1, 0, 0, 16'h0);    step("t3.borrow");
    chk("t3.0999", cnt_a, 16'h0999);
    set_a(0, 1, 0, 0, 0, 16'h0000); step("t3.load0");
    set_a(0, 0, 1, 0, 0, 16'h0);    step("t3.wrap");
    chk("t3.9999", cnt_a, 16'h9999);
    chk("t3.ovf", 16'(ovf_a), 16'h1);

    // Test 4: saturate
    set_a(0, 1, 0, 1, 1, 16'h9999); step("t4.load");
    set_a(0, 0, 1, 1, 1, 16'h0);
    repeat (3) begin
      step("t4.sat");
      chk("t4.sat_ovf", 16'(ovf_a), 16'h1);
    end
    set_a(0, 0, 1, 0, 1, 16'h0);    step("t4.down");
    chk("t4.9998", cnt_a, 16'h9998);

    // Test 5: clamp and priority
    set_a(0, 1, 0, 1, 0, 16'hA3F5); step("t5.clamp");
    chk("t5.9395", cnt_a, 16'h9395);
    set_a(1, 1, 1, 1, 0, 16'h1234); step("t5.clr_pri");
    set_a(0, 1, 1, 1, 0, 16'h1234); step("t5.load_pri");
    chk("t5.1234", cnt_a, 16'h1234);
    set_a(0, 0, 0, 1, 0, 16'h0);

    // Test 6: small instance, full up cycle then clamp
    clr_b = 1; step("t6.clr");
    clr_b = 0; en_b = 1; up_b = 1; sat_b = 0;
    repeat (36) step("t6.up");
    chk("t6.wrap_cnt", 16'(cnt_b), 16'h0);
    chk("t6.wrap_ovf", 16'(ovf_b), 16'h1);
    en_b = 0; load_b = 1; lv_b = 6'o77; step("t6.load77");
    chk("t6.55", 16'(cnt_b), 16'(6'o55));
    load_b = 0;

    // Random phase on both instances
    for (int n = 0; n < 400; n++) begin
      clr_a  = ($urandom_range(0, 99) < 3);
      load_a = ($urandom_range(0, 99) < 8);
      en_a   = ($urandom_range(0, 99) < 85);
      up_a   = $urandom_range(0, 1);
      sat_a  = ($urandom_range(0, 99) < 30);
      lv_a   = ($urandom_range(0, 1) != 0) ? 16'h9999 - 16'($urandom_range(0, 2)) : 16'($urandom);
      clr_b  = ($urandom_range(0, 99) < 3);
      load_b = ($urandom_range(0, 99) < 8);
      en_b   = ($urandom_range(0, 99) < 85);
      up_b   = $urandom_range(0, 1);
      sat_b  = ($urandom_range(0, 99) < 30);
      lv_b   = 6'($urandom);
      step("rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

endmodule

`default_nettype wire
